// File: rtl/axis_flight_if.sv
// Command and mux-select bundle between the flight controller and the axis sequencer.
// The sequencer is the slave: it consumes commands and drives the registered selects.
interface axis_flight_if;
   logic       cmd_valid;
   logic [2:0] cmd_op;
   logic       cmd_ready;
   logic       abort;
   logic [3:0] mode_sel;
   logic [3:0] pos_sel;
   logic       warp_active;
   logic       cmd_err;

   modport master (
      output cmd_valid, cmd_op, abort,
      input  cmd_ready, mode_sel, pos_sel, warp_active, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_op, abort,
      output cmd_ready, mode_sel, pos_sel, warp_active, cmd_err
   );
endinterface

// File: rtl/axis_flight_sequencer.sv
// Flight command sequencer producing registered one-hot velocity/position selects
// for the x/y/z position slices, including the charge/jump/cooldown warp sequence.
module axis_flight_sequencer #(
   parameter int unsigned CHARGE_CYCLES   = 8,
   parameter int unsigned COOLDOWN_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   axis_flight_if.slave  flt
);
   typedef enum logic [2:0] {
      S_INIT, S_CRUISE, S_HOME, S_CHARGE, S_JUMP, S_COOLDOWN
   } state_e;

   localparam logic [2:0] OP_ATTACK  = 3'd1;
   localparam logic [2:0] OP_DEFENSE = 3'd2;
   localparam logic [2:0] OP_STEALTH = 3'd3;
   localparam logic [2:0] OP_STOP    = 3'd4;
   localparam logic [2:0] OP_WARP    = 3'd5;
   localparam logic [2:0] OP_HOME    = 3'd6;
   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   localparam logic [3:0] MODE_ZERO    = 4'b0001;
   localparam logic [3:0] MODE_ATTACK  = 4'b0010;
   localparam logic [3:0] MODE_DEFENSE = 4'b0100;
   localparam logic [3:0] MODE_STEALTH = 4'b1000;
   localparam logic [3:0] POS_HOME     = 4'b0001;
   localparam logic [3:0] POS_INTEG    = 4'b0010;
   localparam logic [3:0] POS_JUMP     = 4'b0100;

   localparam logic [7:0] CHARGE_LOAD   = 8'(CHARGE_CYCLES - 1);
   localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] saved_q, saved_d;
   logic [7:0] charge_cnt_q, charge_cnt_d;
   logic [7:0] cool_cnt_q, cool_cnt_d;
   logic [3:0] mode_sel_q, mode_sel_d;
   logic [3:0] pos_sel_q, pos_sel_d;
   logic       ready_q, ready_d;
   logic       warp_q, warp_d;
   logic       err_q, err_d;

   logic       accept;
   logic       is_mode_op;
   logic [3:0] op_mode;

   // ready_q always mirrors the current state, so it doubles as the accept qualifier
   assign accept = flt.cmd_valid & ready_q;

   always_comb begin
      is_mode_op = 1'b1;
      op_mode    = MODE_ZERO;
      case (flt.cmd_op)
         OP_ATTACK:  op_mode = MODE_ATTACK;
         OP_DEFENSE: op_mode = MODE_DEFENSE;
         OP_STEALTH: op_mode = MODE_STEALTH;
         OP_STOP:    op_mode = MODE_ZERO;
         default:    is_mode_op = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      saved_d      = saved_q;
      charge_cnt_d = charge_cnt_q;
      cool_cnt_d   = cool_cnt_q;
      err_d        = 1'b0;
      case (state_q)
         S_INIT: state_d = S_CRUISE;
         S_CRUISE: begin
            if (accept) begin
               if (is_mode_op) begin
                  saved_d = op_mode;
               end else if (flt.cmd_op == OP_WARP) begin
                  state_d      = S_CHARGE;
                  charge_cnt_d = CHARGE_LOAD;
               end else if (flt.cmd_op == OP_HOME) begin
                  state_d = S_HOME;
               end else if (flt.cmd_op == OP_ILLEGAL) begin
                  err_d = 1'b1;
               end
            end
         end
         S_HOME: state_d = S_CRUISE;
         S_CHARGE: begin
            if (flt.abort) begin
               state_d = S_CRUISE;
            end else if (charge_cnt_q == 8'd0) begin
               state_d = S_JUMP;
            end else begin
               charge_cnt_d = charge_cnt_q - 8'd1;
            end
         end
         S_JUMP: begin
            state_d    = S_COOLDOWN;
            cool_cnt_d = COOLDOWN_LOAD;
         end
         S_COOLDOWN: begin
            if (accept) begin
               if (is_mode_op) saved_d = op_mode;
               else if (flt.cmd_op != 3'd0) err_d = 1'b1;
            end
            if (cool_cnt_q == 8'd0) state_d = S_CRUISE;
            else cool_cnt_d = cool_cnt_q - 8'd1;
         end
         default: state_d = S_INIT;
      endcase

      // Selects are decoded from the next state and then registered
      mode_sel_d = saved_d;
      pos_sel_d  = POS_INTEG;
      ready_d    = 1'b0;
      warp_d     = 1'b0;
      case (state_d)
         S_INIT: begin
            mode_sel_d = MODE_ZERO;
            pos_sel_d  = POS_HOME;
         end
         S_CRUISE:   ready_d = 1'b1;
         S_HOME:     pos_sel_d = POS_HOME;
         S_CHARGE: begin
            mode_sel_d = MODE_ZERO;
            warp_d     = 1'b1;
         end
         S_JUMP: begin
            mode_sel_d = MODE_ZERO;
            pos_sel_d  = POS_JUMP;
            warp_d     = 1'b1;
         end
         S_COOLDOWN: ready_d = 1'b1;
         default: begin
            mode_sel_d = MODE_ZERO;
            pos_sel_d  = POS_HOME;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_INIT;
         saved_q      <= MODE_ZERO;
         charge_cnt_q <= 8'd0;
         cool_cnt_q   <= 8'd0;
         mode_sel_q   <= MODE_ZERO;
         pos_sel_q    <= POS_HOME;
         ready_q      <= 1'b0;
         warp_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         saved_q      <= saved_d;
         charge_cnt_q <= charge_cnt_d;
         cool_cnt_q   <= cool_cnt_d;
         mode_sel_q   <= mode_sel_d;
         pos_sel_q    <= pos_sel_d;
         ready_q      <= ready_d;
         warp_q       <= warp_d;
         err_q        <= err_d;
      end
   end

   assign flt.mode_sel    = mode_sel_q;
   assign flt.pos_sel     = pos_sel_q;
   assign flt.cmd_ready   = ready_q;
   assign flt.warp_active = warp_q;
   assign flt.cmd_err     = err_q;
endmodule
